// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: paces ball steps, detects wall/paddle/goal contacts,
// issues bounce commands and runs the serve/point/game-over flow.
module pong_game_ctrl #(
  parameter int unsigned SCREEN_X     = 640,
  parameter int unsigned SCREEN_Y     = 480,
  parameter int unsigned PAD_X_L      = 16,
  parameter int unsigned PAD_X_R      = 616,
  parameter int unsigned PAD_W        = 8,
  parameter int unsigned PAD_H        = 64,
  parameter int unsigned SPEED        = 10,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned WIN_SCORE    = 9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  input  logic [7:0] ball_w,
  input  logic [7:0] ball_h,
  input  logic [9:0] pad_l_y,
  input  logic [9:0] pad_r_y,
  output logic [1:0] bounce,
  output logic       move_en,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [1:0] winner,
  output logic [2:0] game_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SERVE    = 3'd1,
    S_PLAY     = 3'd2,
    S_POINT    = 3'd3,
    S_GAMEOVER = 3'd4
  } state_e;

  localparam int unsigned FW = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

  localparam logic [FW-1:0] FRAME_LAST = FW'(SERVE_FRAMES - 1);
  localparam logic [7:0]    STEP_LAST  = 8'(SPEED - 1);
  localparam logic [3:0]    WIN        = 4'(WIN_SCORE);
  localparam logic [10:0]   SX         = 11'(SCREEN_X);
  localparam logic [10:0]   SY         = 11'(SCREEN_Y);
  localparam logic [10:0]   PXL        = 11'(PAD_X_L);
  localparam logic [10:0]   PXL_E      = 11'(PAD_X_L + PAD_W);
  localparam logic [10:0]   PXR        = 11'(PAD_X_R);
  localparam logic [10:0]   PXR_E      = 11'(PAD_X_R + PAD_W);
  localparam logic [10:0]   PH         = 11'(PAD_H);

  localparam logic [1:0] B_NONE  = 2'b00;
  localparam logic [1:0] B_PAD   = 2'b01;
  localparam logic [1:0] B_WALL  = 2'b10;
  localparam logic [1:0] B_SERVE = 2'b11;

  state_e        state_q, state_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [7:0]    step_q, step_d;
  logic          move_en_q, move_en_d;
  logic          chk1_q, chk1_d;
  logic          chk2_q, chk2_d;
  logic [1:0]    bounce_q, bounce_d;
  logic          pad_lock_q, pad_lock_d;
  logic          wall_lock_q, wall_lock_d;
  logic [3:0]    score_l_q, score_l_d;
  logic [3:0]    score_r_q, score_r_d;
  logic [1:0]    winner_q, winner_d;
  logic          pt_right_q, pt_right_d;
  logic          serve_go;

  // Contact detection, all in 11 bits so no sum can wrap
  logic [10:0] bx, by, bx_end, by_end, pl_top, pr_top, pl_end, pr_end;
  logic        goal_l, goal_r, hit_l, hit_r, pad_hit, wall_hit;

  assign bx     = {1'b0, ball_x};
  assign by     = {1'b0, ball_y};
  assign bx_end = bx + {3'b000, ball_w};
  assign by_end = by + {3'b000, ball_h};
  assign pl_top = {1'b0, pad_l_y};
  assign pr_top = {1'b0, pad_r_y};
  assign pl_end = pl_top + PH;
  assign pr_end = pr_top + PH;

  assign goal_l   = (ball_x == '0);
  assign goal_r   = (bx_end >= SX);
  assign hit_l    = (bx < PXL_E) && (bx_end > PXL) && (by < pl_end) && (by_end > pl_top);
  assign hit_r    = (bx < PXR_E) && (bx_end > PXR) && (by < pr_end) && (by_end > pr_top);
  assign pad_hit  = hit_l | hit_r;
  assign wall_hit = (ball_y == '0) || (by_end >= SY);

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  always_comb begin
    state_d     = state_q;
    frame_d     = frame_q;
    step_d      = step_q;
    bounce_d    = B_NONE;
    chk1_d      = move_en_q;
    chk2_d      = chk1_q;
    pad_lock_d  = pad_lock_q;
    wall_lock_d = wall_lock_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    winner_d    = winner_q;
    pt_right_d  = pt_right_q;
    serve_go    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          score_l_d = '0;
          score_r_d = '0;
          winner_d  = '0;
          serve_go  = 1'b1;
        end
      end

      S_SERVE: begin
        // the entry cycle (bounce_q==serve) never counts a frame tick
        if (frame_tick && (bounce_q != B_SERVE)) begin
          if (frame_q == FRAME_LAST) begin
            state_d = S_PLAY;
            step_d  = '0;
          end else begin
            frame_d = frame_q + 1'b1;
          end
        end
      end

      S_PLAY: begin
        step_d = (step_q == STEP_LAST) ? '0 : step_q + 8'd1;
        if (chk2_q) begin
          if (goal_l || goal_r) begin
            state_d    = S_POINT;
            pt_right_d = goal_l;
          end else begin
            // a paddle contact, even a locked-out one, masks the wall
            if (pad_hit && !pad_lock_q) begin
              bounce_d = B_PAD;
            end else if (!pad_hit && wall_hit && !wall_lock_q) begin
              bounce_d = B_WALL;
            end
            pad_lock_d  = pad_hit && (pad_lock_q || (bounce_d == B_PAD));
            wall_lock_d = wall_hit && (wall_lock_q || (bounce_d == B_WALL));
          end
        end
      end

      S_POINT: begin
        if (pt_right_q) begin
          score_r_d = sat_inc(score_r_q);
          if (score_r_d == WIN) begin
            state_d  = S_GAMEOVER;
            winner_d = 2'b10;
          end else begin
            serve_go = 1'b1;
          end
        end else begin
          score_l_d = sat_inc(score_l_q);
          if (score_l_d == WIN) begin
            state_d  = S_GAMEOVER;
            winner_d = 2'b01;
          end else begin
            serve_go = 1'b1;
          end
        end
      end

      S_GAMEOVER: begin
        if (start) begin
          score_l_d = '0;
          score_r_d = '0;
          winner_d  = '0;
          serve_go  = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (serve_go) begin
      state_d     = S_SERVE;
      bounce_d    = B_SERVE;
      frame_d     = '0;
      pad_lock_d  = 1'b0;
      wall_lock_d = 1'b0;
    end

    move_en_d = (state_d == S_PLAY) && (step_d == STEP_LAST);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      frame_q     <= '0;
      step_q      <= '0;
      move_en_q   <= 1'b0;
      chk1_q      <= 1'b0;
      chk2_q      <= 1'b0;
      bounce_q    <= B_NONE;
      pad_lock_q  <= 1'b0;
      wall_lock_q <= 1'b0;
      score_l_q   <= '0;
      score_r_q   <= '0;
      winner_q    <= '0;
      pt_right_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      step_q      <= step_d;
      move_en_q   <= move_en_d;
      chk1_q      <= chk1_d;
      chk2_q      <= chk2_d;
      bounce_q    <= bounce_d;
      pad_lock_q  <= pad_lock_d;
      wall_lock_q <= wall_lock_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      winner_q    <= winner_d;
      pt_right_q  <= pt_right_d;
    end
  end

  assign bounce     = bounce_q;
  assign move_en    = move_en_q;
  assign score_l    = score_l_q;
  assign score_r    = score_r_q;
  assign winner     = winner_q;
  assign game_state = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl: directed game scenarios push expected
// bounce events; a negedge monitor pops and compares whenever bounce is nonzero.
module tb_pong_game_ctrl;

  localparam int SPEED = 10;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic [9:0] ball_x, ball_y, pad_l_y, pad_r_y;
  logic [7:0] ball_w, ball_h;
  logic [1:0] bounce;
  logic       move_en;
  logic [3:0] score_l, score_r;
  logic [1:0] winner;
  logic [2:0] game_state;

  always #5 clock = ~clock;

  pong_game_ctrl #(
    .SPEED(SPEED),
    .SERVE_FRAMES(2),
    .WIN_SCORE(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .frame_tick(frame_tick),
    .start(start),
    .ball_x(ball_x),
    .ball_y(ball_y),
    .ball_w(ball_w),
    .ball_h(ball_h),
    .pad_l_y(pad_l_y),
    .pad_r_y(pad_r_y),
    .bounce(bounce),
    .move_en(move_en),
    .score_l(score_l),
    .score_r(score_r),
    .winner(winner),
    .game_state(game_state)
  );

  typedef struct {
    logic [1:0] b;
    logic [3:0] sl;
    logic [3:0] sr;
    logic [2:0] st;
  } exp_t;

  exp_t exq[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  task automatic expect_ev(input int b, input int sl, input int sr, input int st);
    exp_t e;
    e.b  = 2'(b);
    e.sl = 4'(sl);
    e.sr = 4'(sr);
    e.st = 3'(st);
    exq.push_back(e);
  endtask

  // Monitor: every nonzero bounce must match the next queued expectation
  always @(negedge clock) begin
    if (reset && (bounce != 2'b00)) begin
      if (exq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_bounce: got %0d, expected none (t=%0t)", bounce, $time);
      end else begin
        mon_e = exq.pop_front();
        chk("ev_bounce", int'(bounce), int'(mon_e.b));
        chk("ev_score_l", int'(score_l), int'(mon_e.sl));
        chk("ev_score_r", int'(score_r), int'(mon_e.sr));
        chk("ev_state", int'(game_state), int'(mon_e.st));
      end
    end
  end

  task automatic wait_me(output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!move_en && n < 50);
    if (!move_en) fail("move_en_timeout");
  endtask

  task automatic wait_bounce(output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while ((bounce == 2'b00) && n < 30);
    if (bounce == 2'b00) fail("bounce_timeout");
  endtask

  task automatic pulse_tick();
    @(negedge clock);
    frame_tick = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic serve_to_play();
    repeat (2) @(negedge clock);
    pulse_tick();
    repeat (2) @(negedge clock);
    pulse_tick();
    chk("serve_to_play_state", int'(game_state), 2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog_expired (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cnt;
    ball_x  = 10'd320;
    ball_y  = 10'd200;
    ball_w  = 8'd5;
    ball_h  = 8'd5;
    pad_l_y = 10'd0;
    pad_r_y = 10'd0;
    #1 reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_state", int'(game_state), 0);
    chk("rst_bounce", int'(bounce), 0);
    chk("rst_move_en", int'(move_en), 0);
    chk("rst_scores", int'({score_l, score_r}), 0);
    chk("rst_winner", int'(winner), 0);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("idle_hold", int'(game_state), 0);

    // start: serve pulse one cycle later, then countdown of two frames
    expect_ev(3, 0, 0, 1);
    pulse_start();
    chk("serve_state", int'(game_state), 1);
    repeat (2) @(negedge clock);
    pulse_tick();
    chk("serve_after_one_tick", int'(game_state), 1);
    repeat (2) @(negedge clock);
    @(negedge clock);
    frame_tick = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0;
    chk("play_entry", int'(game_state), 2);
    wait_me(n);
    chk("first_move_en_latency", n + 1, SPEED);
    wait_me(n);
    chk("move_en_period", n, SPEED);

    // top wall, then held contact must not re-trigger
    ball_y = 10'd0;
    expect_ev(2, 0, 0, 2);
    wait_bounce(n);
    chk("wall_latency", n, 3);
    repeat (3) wait_me(n);

    // left paddle hit, then miss, then simultaneous wall+paddle
    ball_x  = 10'd20;
    ball_y  = 10'd100;
    pad_l_y = 10'd80;
    expect_ev(1, 0, 0, 2);
    wait_bounce(n);
    chk("pad_latency", n, 3);
    wait_me(n);
    pad_l_y = 10'd200;
    wait_me(n);
    pad_l_y = 10'd0;
    ball_y  = 10'd0;
    expect_ev(1, 0, 0, 2);
    wait_bounce(n);
    chk("wall_pad_latency", n, 3);
    wait_me(n);
    ball_x  = 10'd320;
    ball_y  = 10'd200;
    wait_me(n);

    // start during play is ignored
    pulse_start();
    @(negedge clock);
    chk("start_ignored_play", int'(game_state), 2);

    // left goal: point to right
    wait_me(n);
    ball_x = 10'd0;
    expect_ev(3, 0, 1, 1);
    repeat (3) @(negedge clock);
    chk("point_state", int'(game_state), 3);
    @(negedge clock);
    chk("serve_after_point", int'(game_state), 1);
    ball_x = 10'd320;
    serve_to_play();

    // two right goals: left wins with WIN_SCORE=2
    wait_me(n);
    ball_x = 10'd636;
    expect_ev(3, 1, 1, 1);
    repeat (4) @(negedge clock);
    chk("score_l_first", int'(score_l), 1);
    ball_x = 10'd320;
    serve_to_play();
    wait_me(n);
    ball_x = 10'd636;
    repeat (4) @(negedge clock);
    ball_x = 10'd320;
    chk("gameover_state", int'(game_state), 4);
    chk("gameover_score_l", int'(score_l), 2);
    chk("gameover_score_r", int'(score_r), 1);
    chk("gameover_winner", int'(winner), 1);
    cnt = 0;
    repeat (30) begin
      @(negedge clock);
      if (move_en) cnt++;
    end
    chk("gameover_move_en_count", cnt, 0);
    chk("gameover_hold", int'(game_state), 4);

    // restart clears scores and winner
    expect_ev(3, 0, 0, 1);
    pulse_start();
    chk("restart_winner", int'(winner), 0);

    // reach score_l=1, then reset mid-countdown
    serve_to_play();
    wait_me(n);
    ball_x = 10'd636;
    expect_ev(3, 1, 0, 1);
    repeat (4) @(negedge clock);
    ball_x = 10'd320;
    chk("pre_reset_score_l", int'(score_l), 1);
    pulse_tick();
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_state", int'(game_state), 0);
    chk("async_rst_score_l", int'(score_l), 0);
    chk("async_rst_bounce", int'(bounce), 0);
    chk("async_rst_move_en", int'(move_en), 0);
    chk("async_rst_winner", int'(winner), 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    pulse_tick();
    repeat (3) @(negedge clock);
    chk("idle_after_reset", int'(game_state), 0);
    expect_ev(3, 0, 0, 1);
    pulse_start();
    chk("start_after_reset", int'(game_state), 1);

    repeat (3) @(negedge clock);
    while (exq.size() > 0) begin
      mon_e = exq.pop_front();
      $display("FAIL missing_bounce: got none, expected %0d", mon_e.b);
      n_cmp++;
      n_bad++;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Game-sequencing controller for the Pong ball datapath. It paces ball motion with a step strobe and detects wall, paddle and goal contacts from the ball and paddle positions. It drives the 2-bit `bounce` command the ball FSM consumes, keeps both scores and runs the serve/point/game-over sequence. It sits between the ball FSM, the two paddle blocks and the VGA frame timing.

## Interface
Parameters:
- SCREEN_X, 640, playfield width in pixels
- SCREEN_Y, 480, playfield height in pixels
- PAD_X_L, 16, left paddle left edge x
- PAD_X_R, 616, right paddle left edge x
- PAD_W, 8, paddle width
- PAD_H, 64, paddle height
- SPEED, 10, clocks per ball step (2..255)
- SERVE_FRAMES, 60, frame_tick pulses to wait before play resumes
- WIN_SCORE, 9, score that ends the game (1..15)

Ports:
- clock  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- frame_tick  in  1  one-cycle pulse per video frame
- start  in  1  one-cycle pulse to begin or restart a game
- ball_x, ball_y  in  10  ball top-left position
- ball_w, ball_h  in  8  ball size
- pad_l_y, pad_r_y  in  10  paddle top edges
- bounce  out  2  00 none, 01 paddle, 10 wall, 11 serve (re-throw)
- move_en  out  1  ball step strobe
- score_l, score_r  out  4  player scores
- winner  out  2  00 none, 01 left, 10 right
- game_state  out  3  current FSM state encoding

## Operation
- States: IDLE=0, SERVE=1, PLAY=2, POINT=3, GAMEOVER=4.
- IDLE → SERVE on `start`. Scores are cleared on that transition.
- On entry to SERVE, `bounce`=11 for exactly one cycle. The controller then counts SERVE_FRAMES `frame_tick` pulses and moves to PLAY on the last one.
- PLAY has a step counter that runs 0..SPEED-1. `move_en`=1 on the cycle where the counter equals SPEED-1. The counter restarts at 0 on entry to PLAY.
- A check cycle occurs 2 cycles after each `move_en`. On the check cycle, contacts are evaluated from the inputs, using 11-bit sums with no overflow:
  - goal_l: ball_x==0. goal_r: ball_x+ball_w ≥ SCREEN_X.
  - pad contact: horizontal overlap with [PAD_X, PAD_X+PAD_W) and vertical overlap ball_y < pad_y+PAD_H and ball_y+ball_h > pad_y. This applies to both paddles.
  - wall: ball_y==0 or ball_y+ball_h ≥ SCREEN_Y.
- Priority on the check cycle is goal > paddle > wall.
  - Goal: go to POINT and credit the opponent. goal_l gives a point to right; goal_r gives a point to left.
  - Paddle or wall: `bounce` is 01 or 10 for one cycle, issued the cycle after the check.
- Re-trigger lockout: a paddle bounce is not reissued until a check finds no paddle contact. Walls use their own separate lockout. Both lockouts clear on SERVE entry.
- POINT lasts one cycle and increments the credited score. If that score reaches WIN_SCORE, go to GAMEOVER and set `winner`. Otherwise go to SERVE.
- GAMEOVER holds the scores and `winner`. `move_en` stays 0. A `start` pulse clears the scores and `winner` and goes to SERVE.
- A `start` pulse in SERVE, PLAY or POINT is ignored.
- Scores saturate at 15.

## Timing
- Reset values: state IDLE, `bounce`=00, `move_en`=0, scores 0, `winner`=00, counters 0, lockouts clear.
- All outputs are registered.
- `bounce` is nonzero for exactly 1 cycle per event, then returns to 00.
- `move_en` is never asserted outside PLAY.
- Latency:
  - `move_en` to check cycle: 2 clocks.
  - Check cycle to `bounce` or POINT: 1 clock.
  - POINT to the SERVE `bounce`=11 pulse: 1 clock.
- If `frame_tick` coincides with SERVE entry, it is not counted.
- Reset asserted mid-game returns the block to IDLE asynchronously. There is no partial score update.

## Test plan
- Reset, then `start`, with SERVE_FRAMES=2: `bounce`=11 one cycle after `start`. PLAY begins on the 2nd `frame_tick`. The first `move_en` follows SPEED clocks later, and the next every 10 clocks.
- ball_y=0, ball_x=320 in PLAY: `bounce`=10 for one cycle, 3 clocks after `move_en`. Holding ball_y=0 over further checks produces no repeat.
- ball_x=20, ball_y=100, pad_l_y=80, ball 5×5: `bounce`=01. Setting pad_l_y=200 instead gives no bounce. A simultaneous wall+paddle contact gives 01.
- ball_x=0: POINT, score_r increments by 1, `bounce`=11 on the next cycle, state SERVE.
- WIN_SCORE=2, two goals at the right edge: score_l=2, `winner`=01, GAMEOVER, `move_en` stays 0. A `start` pulse clears the scores and re-serves.
- Assert reset during SERVE countdown with score_l=1: all outputs return to reset values immediately. After reset is released, state stays IDLE until `start`.
